// File: rtl/projective_to_affine.sv
// ---------------------------------------------------------------------------
// projective_to_affine
//
// Converts a Curve25519 projective x-coordinate pair (X, Z) into the affine
// coordinate x = X * Z^(p-2) mod p, with p = 2^255 - 19. The inverse of Z is
// obtained by Fermat exponentiation, using left-to-right square-and-multiply.
// Every field multiply runs on one internal bit-serial interleaved multiplier
// that consumes one multiplier bit per cycle.
//
// Ports:
//   aff_clk         single clock, rising edge
//   aff_reset_n     asynchronous, active-low reset
//   aff_valid       one-cycle start pulse, sampled only while idle
//   aff_x_in        projective X (ladder Rx)
//   aff_z_in        projective Z (ladder Rz)
//   aff_x_out       affine x in [0, p), held until the next result
//   aff_data_valid  one-cycle pulse marking a new aff_x_out
//   aff_busy        high from the accept edge until the result is issued
// ---------------------------------------------------------------------------
module projective_to_affine #(
    parameter int WIDTH = 255
) (
    input  logic             aff_clk,
    input  logic             aff_reset_n,
    input  logic             aff_valid,
    input  logic [WIDTH-1:0] aff_x_in,
    input  logic [WIDTH-1:0] aff_z_in,
    output logic [WIDTH-1:0] aff_x_out,
    output logic             aff_data_valid,
    output logic             aff_busy
);

    // p = 2^255 - 19: all ones above bit 4, low five bits 01101.
    // The extra top bit leaves room for the 256-bit intermediates.
    localparam logic [WIDTH:0] P_EXT = {1'b0, {(WIDTH-5){1'b1}}, 5'b01101};

    // Exponent e = p - 2: low five bits 01011, so bits 2 and 4 are zero.
    localparam logic [WIDTH-1:0] EXP = {{(WIDTH-5){1'b1}}, 5'b01011};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [7:0]       i_q, i_d;
    logic [7:0]       j_q, j_d;
    logic             sq_pending_q, sq_pending_d;
    logic             final_q, final_d;
    logic             z_done_q, z_done_d;
    logic             is_sq_q, is_sq_d;
    logic [WIDTH-1:0] x_out_q, x_out_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;

    // Input reduction. Any WIDTH-bit value is below 2p, so a single
    // conditional subtract brings it into [0, p) and cannot underflow.
    logic [WIDTH:0]   x_ext, z_ext;
    logic [WIDTH-1:0] x_red, z_red;

    always_comb begin
        x_ext = {1'b0, aff_x_in};
        z_ext = {1'b0, aff_z_in};
        if (x_ext >= P_EXT) begin
            x_ext = x_ext - P_EXT;
        end
        if (z_ext >= P_EXT) begin
            z_ext = z_ext - P_EXT;
        end
        x_red = x_ext[WIDTH-1:0];
        z_red = z_ext[WIDTH-1:0];
    end

    // One interleaved multiplier step: r <- 2r + b[j]*a, reduced mod p.
    // r and a are both below p, so each stage stays below 2p and one
    // conditional subtract per stage keeps the running value in [0, p).
    logic [WIDTH:0]   t_dbl, t_red, t_add, t_fin;
    logic [WIDTH-1:0] mul_next;

    always_comb begin
        t_dbl = {r_q, 1'b0};
        t_red = t_dbl;
        if (t_dbl >= P_EXT) begin
            t_red = t_dbl - P_EXT;
        end
        t_add = t_red;
        if (b_q[j_q]) begin
            t_add = t_red + {1'b0, a_q};
        end
        t_fin = t_add;
        if (t_add >= P_EXT) begin
            t_fin = t_add - P_EXT;
        end
        mul_next = t_fin[WIDTH-1:0];
    end

    // After every reduction the top bit is provably zero.
    logic unused_msbs;
    assign unused_msbs = ^{x_ext[WIDTH], z_ext[WIDTH], t_fin[WIDTH]};

    // Next-state logic for the exponentiation schedule. The multiply that
    // DISPATCH issues is chosen from the flags alone:
    //   sq_pending        -> square acc
    //   e[i] and not yet  -> acc * Z for bit i
    //   otherwise         -> final acc * X (only reachable with i = 0)
    // On multiply completion the schedule either stays on bit i (a square
    // of a one-bit still owes its Z multiply) or steps to bit i-1.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        z_d          = z_q;
        acc_d        = acc_q;
        r_d          = r_q;
        a_d          = a_q;
        b_d          = b_q;
        i_d          = i_q;
        j_d          = j_q;
        sq_pending_d = sq_pending_q;
        final_d      = final_q;
        z_done_d     = z_done_q;
        is_sq_d      = is_sq_q;
        x_out_d      = x_out_q;
        data_valid_d = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (aff_valid) begin
                    x_d          = x_red;
                    z_d          = z_red;
                    // Bit 254 of e is one, so acc starts as Z itself.
                    acc_d        = z_red;
                    i_d          = 8'(WIDTH - 2);
                    sq_pending_d = 1'b1;
                    final_d      = 1'b0;
                    z_done_d     = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_DISPATCH;
                end
            end

            S_DISPATCH: begin
                r_d     = '0;
                j_d     = 8'(WIDTH - 1);
                state_d = S_MUL;
                if (sq_pending_q) begin
                    a_d          = acc_q;
                    b_d          = acc_q;
                    sq_pending_d = 1'b0;
                    z_done_d     = 1'b0;
                    is_sq_d      = 1'b1;
                end else if (EXP[i_q] && !z_done_q) begin
                    a_d      = z_q;
                    b_d      = acc_q;
                    z_done_d = 1'b1;
                    is_sq_d  = 1'b0;
                end else begin
                    a_d     = x_q;
                    b_d     = acc_q;
                    final_d = 1'b1;
                    is_sq_d = 1'b0;
                end
            end

            S_MUL: begin
                r_d = mul_next;
                if (j_q == 8'd0) begin
                    acc_d = mul_next;
                    if (final_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DISPATCH;
                        // A square on a one-bit leaves i alone so the
                        // Z multiply for that bit is issued next.
                        if (!(is_sq_q && EXP[i_q])) begin
                            if (i_q != 8'd0) begin
                                i_d          = i_q - 8'd1;
                                sq_pending_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    j_d = j_q - 8'd1;
                end
            end

            S_DONE: begin
                x_out_d      = acc_q;
                data_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset clears everything, which also
    // aborts an in-flight conversion without producing a result pulse.
    always_ff @(posedge aff_clk or negedge aff_reset_n) begin
        if (!aff_reset_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            z_q          <= '0;
            acc_q        <= '0;
            r_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            sq_pending_q <= 1'b0;
            final_q      <= 1'b0;
            z_done_q     <= 1'b0;
            is_sq_q      <= 1'b0;
            x_out_q      <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            z_q          <= z_d;
            acc_q        <= acc_d;
            r_q          <= r_d;
            a_q          <= a_d;
            b_q          <= b_d;
            i_q          <= i_d;
            j_q          <= j_d;
            sq_pending_q <= sq_pending_d;
            final_q      <= final_d;
            z_done_q     <= z_done_d;
            is_sq_q      <= is_sq_d;
            x_out_q      <= x_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign aff_x_out      = x_out_q;
    assign aff_data_valid = data_valid_q;
    assign aff_busy       = busy_q;

endmodule

// File: doc/projective_to_affine.md
# projective_to_affine

Converts a Curve25519 projective x-coordinate pair (X, Z) into the affine coordinate x = X·Z^(p−2) mod p, where p = 2^255 − 19. It sits directly downstream of the Montgomery ladder and consumes that block's (Rx, Rz, valid-pulse) result interface. It emits the final 255-bit scalar-multiplication result, or the shared secret.

Inversion uses Fermat exponentiation with left-to-right square-and-multiply. The modular multiplier is an internal bit-serial interleaved unit that processes one multiplier bit per cycle.

## Interface
- WIDTH, 255: field element width; fixed by the prime and not intended for override.
- aff_clk, input, 1: the single clock; all logic is on its rising edge.
- aff_reset_n, input, 1: reset, asynchronous and active-low.
- aff_valid, input, 1: one-cycle start pulse. Sampled only in IDLE.
- aff_x_in, input, WIDTH: projective X. Connects to the ladder's Rx.
- aff_z_in, input, WIDTH: projective Z. Connects to the ladder's Rz.
- aff_x_out, output, WIDTH: affine x, fully reduced to [0, p).
- aff_data_valid, output, 1: one-cycle pulse; aff_x_out is valid on that cycle.
- aff_busy, output, 1: high from the accept edge until the DONE cycle completes.

## Operation
- States: IDLE, DISPATCH, MUL, DONE. Internal registers:
  - X, Z: latched operands.
  - acc: exponentiation accumulator.
  - r: multiplier partial result.
  - a, b: multiplier operands.
  - i: exponent bit index, 8 bits.
  - j: multiplier bit counter, 8 bits.
  - phase flags: sq_pending, final.
- Exponent e = p − 2 = 0x7FFF…FFEB. Bit 254 is 1. Bits 2 and 4 are 0. All other bits 0..253 are 1.
- IDLE, when aff_valid = 1:
  - Latch X and Z. Any operand ≥ p gets one conditional subtract of p; this is sufficient because 2^255 < 2p.
  - acc ← reduced Z, since the top exponent bit is consumed.
  - i ← 253, sq_pending ← 1.
  - Go to DISPATCH.
- DISPATCH selects the next multiply, clears r to 0, sets j ← WIDTH−1, and goes to MUL:
  - sq_pending = 1: set a = b = acc (square), then sq_pending ← 0.
  - Otherwise, if e[i] = 1 and the multiply-by-Z for bit i has not yet been done: set a = Z, b = acc.
  - Otherwise, if i = 0 and final = 0: set a = X, b = acc, final ← 1.
- MUL runs one step per cycle:
  - t = 2r; if t ≥ p, t −= p.
  - If b[j] = 1, t += a; if t ≥ p, t −= p.
  - r ← t. Use 256-bit intermediates.
  - When j = 0: acc ← result. If final = 1, go to DONE. Otherwise advance the exponent schedule and return to DISPATCH:
    - After a square: check bit i.
    - After the Z multiply, or after a square on a zero bit: if i > 0, then i ← i − 1 and sq_pending ← 1; if i = 0, issue the final multiply.
- DONE: aff_x_out ← acc, aff_data_valid ← 1, aff_busy ← 0, then return to IDLE. In IDLE, aff_data_valid is driven 0.
- Multiply count:
  - 254 squarings.
  - 252 multiplies by Z.
  - 1 final multiply by X.
  - N_MUL = 507 in total.
- Z = 0 yields Z^(p−2) = 0, so the output is 0 (point at infinity). No special-casing.
- aff_valid while busy is ignored. It is not queued.
- aff_x_out holds its last result until the next DONE.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE.
  - aff_x_out = 0, aff_data_valid = 0, aff_busy = 0.
  - All internal registers = 0.
- Reset mid-operation aborts the computation with no output pulse. The block accepts aff_valid on the first edge after release.
- Cost per multiply: 1 DISPATCH cycle + WIDTH MUL cycles = 256 cycles.
- Latency: aff_valid is sampled at edge 0. aff_data_valid is high for exactly one cycle, starting at edge N_MUL·256 + 1 = 129,793.
- aff_busy rises at edge 0 and falls together with aff_data_valid rising.
- The earliest next accept is the edge after aff_data_valid.
- Back-to-back operation with the ladder is supported: the ladder's valid pulse connects to aff_valid directly.
- Critical path: two 256-bit compare/subtract stages plus one 256-bit add per MUL cycle.

## Test plan
- X = 9, Z = 1 → aff_x_out = 9. aff_data_valid pulses exactly at edge 129,793. aff_busy is high throughout.
- X = 1, Z = 2 → aff_x_out = 0x3FFF…FFF7, i.e. (p+1)/2 = 2^254 − 9. This checks a true inversion.
- X = 18, Z = 2 → aff_x_out = 9. Then X = p+3, Z = 1 → aff_x_out = 3, which checks input reduction.
- X = 5, Z = 0 → aff_x_out = 0, with a single valid pulse.
- aff_valid pulsed again at cycle 1,000 of a run → ignored: one result only, same value and timing as an undisturbed run.
- aff_reset_n driven low asynchronously mid-MUL, i.e. between clock edges → all outputs read 0 immediately, with no valid pulse. After release, a new X = 9, Z = 1 request completes normally with result 9.
